// File: rtl/serializer.sv
// Parallel-to-serial transmitter: sends the top len bits of a captured word MSB first,
// one bit per clock with a valid strobe, then returns to idle for at least one cycle.
module serializer #(
    parameter int DATA_W = 16,
    parameter int MOD_W  = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              data_val_i,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              busy_o
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic [MOD_W:0]    cnt_reg, cnt_next;
    logic [MOD_W:0]    len;
    logic              len_ok;

    // A modifier of zero stands for a full word; lengths of 1 and 2 are not supported
    always_comb begin
        len    = (data_mod_i == '0) ? (MOD_W+1)'(DATA_W) : {1'b0, data_mod_i};
        len_ok = (len > (MOD_W+1)'(2));
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (data_val_i && len_ok) begin
                    shift_next = data_i;
                    cnt_next   = len;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift_next = {shift_reg[DATA_W-2:0], 1'b0};
                cnt_next   = cnt_reg - 1'b1;
                // The edge ending the final bit goes idle, so requests here are dropped
                if (cnt_reg == (MOD_W+1)'(1))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode only flops, so there is no path from any input
    always_comb begin
        busy_o         = (state_reg == SHIFT);
        ser_data_val_o = (state_reg == SHIFT);
        ser_data_o     = (state_reg == SHIFT) && shift_reg[DATA_W-1];
    end

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer: single words, short lengths, invalid lengths,
// back-to-back bursts, asynchronous reset mid-word and a random request sweep.
module tb_serializer;

    logic        clk_i = 1'b0;
    logic        arst_i = 1'b1;
    logic [15:0] data_i = '0;
    logic [3:0]  data_mod_i = '0;
    logic        data_val_i = 1'b0;
    logic        ser_data_o;
    logic        ser_data_val_o;
    logic        busy_o;

    int n_total = 0;
    int n_bad   = 0;

    serializer #(.DATA_W(16)) dut (
        .clk_i          (clk_i),
        .arst_i         (arst_i),
        .data_i         (data_i),
        .data_mod_i     (data_mod_i),
        .data_val_i     (data_val_i),
        .ser_data_o     (ser_data_o),
        .ser_data_val_o (ser_data_val_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_val"},  32'(ser_data_val_o), 32'd0);
        check({tag, "_bit"},  32'(ser_data_o), 32'd0);
    endtask

    // One request; data_i is disturbed mid-word to show it is only captured at accept
    task automatic run_word(input logic [15:0] d, input logic [3:0] m, input string tag);
        int          len;
        logic [15:0] got;
        len = (m == 4'd0) ? 16 : int'(m);
        got = '0;
        @(negedge clk_i);
        data_i     = d;
        data_mod_i = m;
        data_val_i = 1'b1;
        @(posedge clk_i);
        for (int i = 0; i < len; i++) begin
            @(negedge clk_i);
            data_val_i = 1'b0;
            if (i == 1) begin
                data_i     = ~d;
                data_mod_i = 4'd7;
            end
            check({tag, "_val"},  32'(ser_data_val_o), 32'd1);
            check({tag, "_busy"}, 32'(busy_o), 32'd1);
            check({tag, "_bit"},  32'(ser_data_o), 32'(d[15-i]));
            got = {got[14:0], ser_data_o};
        end
        @(negedge clk_i);
        check_idle({tag, "_end"});
        $display("word %s data=%h mod=%0d len=%0d got=%h", tag, d, m, len, got);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] words [2];
        logic [15:0] rd;
        logic [3:0]  rm;

        // Reset held: outputs must be zero
        #3;
        check_idle("reset_hold");
        @(negedge clk_i);
        @(negedge clk_i);
        arst_i = 1'b0;
        @(negedge clk_i);
        check_idle("reset_rel");

        run_word(16'hA5C3, 4'd0, "full_a5c3");
        run_word(16'hF000, 4'd4, "mod4_f000");
        run_word(16'h4000, 4'd3, "mod3_4000");
        run_word(16'h8001, 4'd15, "mod15_8001");

        // Lengths 1 and 2 are dropped even with the strobe held
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            check_idle("invalid_mod");
            data_i     = 16'hFFFF;
            data_mod_i = (i < 10) ? 4'd1 : 4'd2;
            data_val_i = 1'b1;
        end
        @(negedge clk_i);
        check_idle("invalid_mod_last");
        data_val_i = 1'b0;
        $display("invalid requests mod=1,2 produced no output");

        // Strobe held: two bursts separated by exactly one idle cycle
        words[0] = 16'h1234;
        words[1] = 16'hBEEF;
        @(negedge clk_i);
        data_i     = words[0];
        data_mod_i = 4'd0;
        data_val_i = 1'b1;
        @(posedge clk_i);
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 16; i++) begin
                @(negedge clk_i);
                if (i == 8) begin
                    data_i = (w == 0) ? words[1] : 16'h0F0F;
                    if (w == 1) data_val_i = 1'b0;
                end
                check("b2b_val",  32'(ser_data_val_o), 32'd1);
                check("b2b_bit",  32'(ser_data_o), 32'(words[w][15-i]));
            end
            @(negedge clk_i);
            check_idle("b2b_gap");
            $display("burst %0d data=%h followed by idle cycle", w, words[w]);
        end
        @(negedge clk_i);
        check_idle("b2b_after");

        // Asynchronous reset after bit 5 of a full word
        @(negedge clk_i);
        data_i     = 16'hA5C3;
        data_mod_i = 4'd0;
        data_val_i = 1'b1;
        @(posedge clk_i);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            data_val_i = 1'b0;
            check("arst_pre_bit", 32'(ser_data_o), 32'(rd_bit(16'hA5C3, i)));
        end
        #2;
        arst_i = 1'b1;
        #1;
        check_idle("arst_async");
        @(negedge clk_i);
        arst_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            check_idle("arst_after");
        end
        $display("async reset mid-word abandoned transfer");
        run_word(16'h3C5A, 4'd0, "post_arst");

        // Random sweep of valid and invalid requests
        for (int n = 0; n < 200; n++) begin
            rd = 16'($urandom);
            rm = 4'($urandom_range(0, 15));
            if (rm == 4'd1 || rm == 4'd2) begin
                @(negedge clk_i);
                data_i     = rd;
                data_mod_i = rm;
                data_val_i = 1'b1;
                @(negedge clk_i);
                data_val_i = 1'b0;
                check_idle("rnd_drop");
                $display("rnd drop data=%h mod=%0d", rd, rm);
            end else begin
                run_word(rd, rm, "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    function automatic logic rd_bit(input logic [15:0] d, input int i);
        return d[15-i];
    endfunction

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
- Parallel-to-serial converter: the transmit side of the bit-serial link whose receive side packs bits into DESER_W-wide words.
- Accepts one parallel word plus a bit-count modifier per request.
- Shifts the word out MSB first, one bit per clock, with a per-bit valid strobe.
- Reports busy while a transfer is in progress and drops requests it cannot take.

Parameters:
- DATA_W, 16: parallel word width. Must be a power of two and >= 4.
- MOD_W, $clog2(DATA_W): width of the bit-count modifier. Derived; do not override.

Ports:
- clk_i  input  1  single clock; all logic on rising edge.
- arst_i  input  1  reset, asynchronous, active-high.
- data_i  input  DATA_W  parallel word; bit DATA_W-1 is sent first.
- data_mod_i  input  MOD_W  number of bits to send, taken from the MSB down; 0 means DATA_W bits.
- data_val_i  input  1  request strobe; sampled only when busy_o=0.
- ser_data_o  output  1  serial data bit.
- ser_data_val_o  output  1  ser_data_o carries a valid bit this cycle.
- busy_o  output  1  transfer in progress; new requests are ignored.

Behaviour:
- Reset:
  - While arst_i=1, all outputs and internal state go to 0 immediately, without waiting for a clock edge.
  - Assertion mid-transfer abandons the word; no further bits are sent after release.
  - The first possible accept is the first rising edge with arst_i=0.
- Outputs: all registered. No combinational path from any input to any output.
- Length decode:
  - len = (data_mod_i==0) ? DATA_W : data_mod_i.
  - data_mod_i of 1 or 2 is an invalid request. It is dropped silently: no bits, busy_o stays 0.
- States: IDLE, SHIFT.
- IDLE:
  - busy_o=0, ser_data_val_o=0, ser_data_o=0.
  - On an edge with data_val_i=1 and a valid len: capture data_i into the shift register, load counter=len, go to SHIFT.
- Accept timing: if the accepting edge ends cycle N, then in cycles N+1 .. N+len:
  - ser_data_val_o=1 and busy_o=1;
  - ser_data_o = data_i[DATA_W-1], then data_i[DATA_W-2], and so on down to data_i[DATA_W-len].
- SHIFT:
  - Each edge shifts the word left by one and decrements the counter.
  - The edge that ends the last bit returns to IDLE. Cycle N+len+1 therefore has busy_o=0 and ser_data_val_o=0.
- Back-to-back requests:
  - The earliest next accept is the edge ending cycle N+len+1.
  - This gives exactly one idle cycle between words.
  - data_val_i asserted while busy_o=1 is ignored and not queued, including during the final-bit cycle.
- Input capture: data_i and data_mod_i are captured only at accept. Changes during SHIFT have no effect.
- Bit order: unsent LSBs are never driven.
- Counter: MOD_W+1 bits wide so that len=DATA_W is representable. There is no wrap.

Test Plan:
- After reset, data_i=16'hA5C3, mod=0, one-cycle val → ser_data_val_o high for 16 cycles starting the cycle after accept; ser_data_o sequence 1010_0101_1100_0011; busy_o low on the 17th cycle.
- data_i=16'hF000, mod=4 → exactly 4 valid bits 1,1,1,1, then busy_o=0. Repeat with mod=3 and data 16'h4000 → bits 0,1,0.
- mod=1 and mod=2 requests with val=1 → busy_o, ser_data_val_o and ser_data_o stay 0 for 20 cycles.
- data_val_i held high continuously with mod=0 → each 16-bit burst is followed by exactly one cycle with ser_data_val_o=0, and the next word is accepted at the end of that idle cycle. Changing data_i during a burst does not alter the bits being sent.
- arst_i pulsed asynchronously (between edges) after bit 5 of a 16-bit word → outputs drop to 0 before the next edge. After release: no leftover bits, busy_o=0, and a new request is served normally.
- Random regression: random data, mod and val over 10k requests, with a scoreboard deserializing ser_data_o/ser_data_val_o and comparing to the accepted data and len. Dropped requests (busy or mod 1/2) must produce no output.
